// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART FIFO bridge: register map, STATUS layout,
// the UART "no byte" marker and the TX drain FSM state type.
package uart_fifo_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

  // UART receive data value meaning "nothing available"
  localparam logic [31:0] NO_DATA = 32'hFFFF_FFFF;

  // STATUS register field positions
  localparam int ST_TX_CNT_LSB = 0;
  localparam int ST_RX_CNT_LSB = 8;
  localparam int ST_TX_EMPTY   = 16;
  localparam int ST_TX_FULL    = 17;
  localparam int ST_RX_EMPTY   = 18;
  localparam int ST_RX_FULL    = 19;
  localparam int ST_RX_OVF     = 20;

  // Byte lane that must be strobed to clear rx_overflow through STATUS
  localparam int ST_CLR_STRB = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head. A push while full is accepted
// only when a pop happens in the same cycle (the pop frees the slot).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Next pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Storage array carries no reset; contents are ignored once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped bridge between a valid/ready bus and a byte UART, with a TX
// FIFO drained by a two-state FSM and an RX FIFO filled from the UART.
module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0100,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        uart_dat_we_o,
  output logic        uart_dat_re_o,
  output logic [31:0] uart_dat_di_o,
  input  logic [31:0] uart_dat_do_i,
  input  logic        uart_dat_wait_i
);
  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_e      state_q, state_d;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     tx_head, rx_head;
  logic [CW-1:0]  tx_count, rx_count;
  logic           ovf_q, ovf_d, ovf_set, ovf_clr;
  logic           sel_data, sel_stat, is_wr, rx_avail;
  logic [31:0]    status;
  logic           unused_wdata;

  assign unused_wdata = ^{mem_wdata_i[31:21], mem_wdata_i[19:8]};

  assign sel_data = mem_valid_i && (mem_addr_i == BASE_ADDR + OFF_DATA);
  assign sel_stat = mem_valid_i && (mem_addr_i == BASE_ADDR + OFF_STATUS);
  assign is_wr    = |mem_wstrb_i;
  assign rx_avail = (uart_dat_do_i != NO_DATA);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
    .wdata(mem_wdata_i[7:0]), .rdata(tx_head), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
    .wdata(uart_dat_do_i[7:0]), .rdata(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );

  // STATUS word assembled from registered FIFO state
  always_comb begin
    status                          = '0;
    status[ST_TX_CNT_LSB +: 8]      = 8'(tx_count);
    status[ST_RX_CNT_LSB +: 8]      = 8'(rx_count);
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_TX_FULL]              = tx_full;
    status[ST_RX_EMPTY]             = rx_empty;
    status[ST_RX_FULL]              = rx_full;
    status[ST_RX_OVF]               = ovf_q;
  end

  // Bus decode: every accepted request completes in the cycle it is presented
  always_comb begin
    mem_ready_o = 1'b0;
    mem_rdata_o = '0;
    tx_push     = 1'b0;
    rx_pop      = 1'b0;
    ovf_clr     = 1'b0;
    if (!reset) begin
      if (sel_data) begin
        if (is_wr) begin
          // TX full stalls the write; only the registered count matters
          if (!mem_wstrb_i[0]) begin
            mem_ready_o = 1'b1;
          end else if (!tx_full) begin
            mem_ready_o = 1'b1;
            tx_push     = 1'b1;
          end
        end else begin
          mem_ready_o = 1'b1;
          if (rx_empty) begin
            mem_rdata_o = NO_DATA;
          end else begin
            mem_rdata_o = {24'b0, rx_head};
            rx_pop      = 1'b1;
          end
        end
      end else if (sel_stat) begin
        mem_ready_o = 1'b1;
        if (is_wr) ovf_clr = mem_wstrb_i[ST_CLR_STRB] && mem_wdata_i[ST_RX_OVF];
        else       mem_rdata_o = status;
      end
    end
  end

  // RX capture: a bus pop in the same cycle makes room in a full FIFO
  always_comb begin
    uart_dat_re_o = !reset && rx_avail;
    rx_push       = uart_dat_re_o && (!rx_full || rx_pop);
    ovf_set       = uart_dat_re_o && !rx_push;
    ovf_d         = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  // Sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // TX drain FSM next state and UART write outputs
  always_comb begin
    state_d       = state_q;
    uart_dat_we_o = 1'b0;
    uart_dat_di_o = '0;
    tx_pop        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (!tx_empty) begin
            uart_dat_di_o = {24'b0, tx_head};
            state_d       = S_SEND;
          end
        end
        S_SEND: begin
          uart_dat_we_o = 1'b1;
          uart_dat_di_o = {24'b0, tx_head};
          if (!uart_dat_wait_i) begin
            tx_pop  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // TX drain FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: a per-cycle vector table followed by
// hand-written sequences for stall, overflow, full-FIFO and reset cases.
module tb_uart_fifo_bridge;
  import uart_fifo_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0100;
  localparam logic [31:0] STAT = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid_i, mem_ready_o;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [3:0]  mem_wstrb_i;
  logic        uart_dat_we_o, uart_dat_re_o;
  logic [31:0] uart_dat_di_o, uart_dat_do_i;
  logic        uart_dat_wait_i;

  uart_fifo_bridge #(.BASE_ADDR(BASE), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i), .mem_rdata_o(mem_rdata_o),
    .uart_dat_we_o(uart_dat_we_o), .uart_dat_re_o(uart_dat_re_o),
    .uart_dat_di_o(uart_dat_di_o), .uart_dat_do_i(uart_dat_do_i),
    .uart_dat_wait_i(uart_dat_wait_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Records completed UART handshakes and any cycle with the write strobe up
  logic [7:0] txq[$];
  int         we_cycles = 0;
  always begin
    @(negedge clk);
    #2;
    if (uart_dat_we_o) we_cycles++;
    if (uart_dat_we_o && !uart_dat_wait_i) txq.push_back(uart_dat_di_o[7:0]);
  end

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] dout;
    logic        wt;
    logic        rdy;
    logic [31:0] rdata;
    logic        we;
    logic        re;
    logic [31:0] di;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output logic rdy, output logic [31:0] rd);
    mem_valid_i = 1'b1;
    mem_addr_i  = a;
    mem_wdata_i = wd;
    mem_wstrb_i = st;
    #1;
    rdy = mem_ready_o;
    rd  = mem_rdata_o;
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic        r;
    logic [31:0] d;
    bus(a, 32'h0, 4'h0, r, d);
    chk({nm, ".ready"}, {31'b0, r}, 32'd1);
    chk({nm, ".rdata"}, d, exp);
  endtask

  task automatic wr_chk(input string nm, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st);
    logic        r;
    logic [31:0] d;
    bus(a, wd, st, r, d);
    chk({nm, ".ready"}, {31'b0, r}, 32'd1);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    mem_valid_i     = 1'b0;
    mem_wstrb_i     = 4'h0;
    uart_dat_do_i   = NO_DATA;
    uart_dat_wait_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset with an active bus request and an incoming UART byte
    reset           = 1'b1;
    mem_valid_i     = 1'b1;
    mem_addr_i      = STAT;
    mem_wdata_i     = 32'h0;
    mem_wstrb_i     = 4'h0;
    uart_dat_do_i   = 32'h0000_0012;
    uart_dat_wait_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.ready", {31'b0, mem_ready_o}, 32'd0);
    chk("rst.rdata", mem_rdata_o, 32'd0);
    chk("rst.re", {31'b0, uart_dat_re_o}, 32'd0);
    chk("rst.we", {31'b0, uart_dat_we_o}, 32'd0);
    chk("rst.di", uart_dat_di_o, 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    mem_valid_i   = 1'b0;
    uart_dat_do_i = NO_DATA;

    //          vld  addr       wdata        strb   dout           wt    rdy   rdata          we    re    di
    tbl[0]  = '{1'b1, STAT,      32'h0,       4'h0, NO_DATA,       1'b1, 1'b1, 32'h0005_0000, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, BASE,      32'h41,      4'h1, NO_DATA,       1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, STAT,      32'h0,       4'h0, NO_DATA,       1'b1, 1'b1, 32'h0004_0001, 1'b0, 1'b0, 32'h41};
    tbl[3]  = '{1'b0, BASE,      32'h0,       4'h0, NO_DATA,       1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h41};
    tbl[4]  = '{1'b1, BASE,      32'h42,      4'h1, NO_DATA,       1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h41};
    tbl[5]  = '{1'b1, STAT,      32'h0,       4'h0, 32'h55,        1'b0, 1'b1, 32'h0004_0001, 1'b0, 1'b1, 32'h42};
    tbl[6]  = '{1'b1, BASE,      32'h0,       4'h0, NO_DATA,       1'b0, 1'b1, 32'h55,        1'b1, 1'b0, 32'h42};
    tbl[7]  = '{1'b1, BASE,      32'h0,       4'h0, NO_DATA,       1'b0, 1'b1, NO_DATA,       1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, BASE,      32'h99,      4'h2, NO_DATA,       1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, STAT,      32'h0,       4'h0, NO_DATA,       1'b0, 1'b1, 32'h0005_0000, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, BASE + 8,  32'h0,       4'h0, NO_DATA,       1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, BASE + 1,  32'h5A,      4'h1, NO_DATA,       1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, STAT,      32'h0,       4'h0, NO_DATA,       1'b0, 1'b1, 32'h0005_0000, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, BASE,      32'h0,       4'h0, 32'h0000_01AB, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
    tbl[14] = '{1'b1, BASE,      32'h0,       4'h0, NO_DATA,       1'b0, 1'b1, 32'h0000_00AB, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b1, STAT,      32'h0,       4'h0, NO_DATA,       1'b0, 1'b1, 32'h0005_0000, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      mem_valid_i     = tbl[i].vld;
      mem_addr_i      = tbl[i].addr;
      mem_wdata_i     = tbl[i].wdata;
      mem_wstrb_i     = tbl[i].strb;
      uart_dat_do_i   = tbl[i].dout;
      uart_dat_wait_i = tbl[i].wt;
      #1;
      chk($sformatf("vec%0d.ready", i), {31'b0, mem_ready_o}, {31'b0, tbl[i].rdy});
      chk($sformatf("vec%0d.rdata", i), mem_rdata_o, tbl[i].rdata);
      chk($sformatf("vec%0d.we", i), {31'b0, uart_dat_we_o}, {31'b0, tbl[i].we});
      chk($sformatf("vec%0d.re", i), {31'b0, uart_dat_re_o}, {31'b0, tbl[i].re});
      chk($sformatf("vec%0d.di", i), uart_dat_di_o, tbl[i].di);
      @(negedge clk);
    end
    mem_valid_i   = 1'b0;
    mem_wstrb_i   = 4'h0;
    uart_dat_do_i = NO_DATA;

    // Three bytes drain in order with the UART never busy
    do_reset();
    txq.delete();
    wr_chk("tx3.w0", BASE, 32'h41, 4'h1);
    wr_chk("tx3.w1", BASE, 32'h42, 4'h1);
    wr_chk("tx3.w2", BASE, 32'h43, 4'h1);
    repeat (12) @(negedge clk);
    chk("tx3.count", txq.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("tx3.byte%0d", i), (i < txq.size()) ? {24'b0, txq[i]} : 32'hDEAD,
          32'h41 + i);
    rd_chk("tx3.status", STAT, 32'h0005_0000);

    // TX full with the UART busy: 17th write stalls until a byte drains
    do_reset();
    txq.delete();
    uart_dat_wait_i = 1'b1;
    for (int i = 0; i < 16; i++)
      wr_chk($sformatf("txfull.w%0d", i), BASE, 32'h10 + i, 4'h1);
    mem_valid_i = 1'b1;
    mem_addr_i  = BASE;
    mem_wdata_i = 32'h20;
    mem_wstrb_i = 4'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("txfull.stall%0d", i), {31'b0, mem_ready_o}, 32'd0);
      @(negedge clk);
    end
    uart_dat_wait_i = 1'b0;
    #1;
    chk("txfull.stall_on_drain", {31'b0, mem_ready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("txfull.release", {31'b0, mem_ready_o}, 32'd1);
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
    repeat (40) @(negedge clk);
    chk("txfull.drained", txq.size(), 32'd17);
    for (int i = 0; i < 17; i++)
      chk($sformatf("txfull.byte%0d", i), (i < txq.size()) ? {24'b0, txq[i]} : 32'hDEAD,
          32'h10 + i);
    rd_chk("txfull.status", STAT, 32'h0005_0000);

    // Single RX byte then empty read
    do_reset();
    uart_dat_do_i = 32'h55;
    #1;
    chk("rx1.re", {31'b0, uart_dat_re_o}, 32'd1);
    @(negedge clk);
    uart_dat_do_i = NO_DATA;
    rd_chk("rx1.read0", BASE, 32'h0000_0055);
    rd_chk("rx1.read1", BASE, NO_DATA);

    // RX overflow, clear, and set-wins-over-clear
    do_reset();
    for (int i = 0; i < 17; i++) begin
      uart_dat_do_i = 32'h60 + i;
      @(negedge clk);
    end
    uart_dat_do_i = NO_DATA;
    rd_chk("ovf.status", STAT, 32'h0019_1000);
    wr_chk("ovf.clear", STAT, 32'h0010_0000, 4'h4);
    rd_chk("ovf.cleared", STAT, 32'h0009_1000);
    uart_dat_do_i = 32'h88;
    wr_chk("ovf.clear_race", STAT, 32'h0010_0000, 4'h4);
    uart_dat_do_i = NO_DATA;
    rd_chk("ovf.set_wins", STAT, 32'h0019_1000);
    wr_chk("ovf.clear2", STAT, 32'h0010_0000, 4'h4);
    rd_chk("ovf.cleared2", STAT, 32'h0009_1000);

    // Full RX FIFO: bus pop and capture in the same cycle
    uart_dat_do_i = 32'h77;
    rd_chk("rxpop.head", BASE, 32'h0000_0060);
    uart_dat_do_i = NO_DATA;
    rd_chk("rxpop.status", STAT, 32'h0009_1000);
    for (int i = 0; i < 15; i++)
      rd_chk($sformatf("rxpop.r%0d", i), BASE, 32'h61 + i);
    rd_chk("rxpop.last", BASE, 32'h0000_0077);
    rd_chk("rxpop.empty", BASE, NO_DATA);
    rd_chk("rxpop.final", STAT, 32'h0005_0000);

    // Reset in SEND with five bytes queued
    do_reset();
    uart_dat_wait_i = 1'b1;
    for (int i = 0; i < 5; i++)
      wr_chk($sformatf("rstsend.w%0d", i), BASE, 32'hA0 + i, 4'h1);
    #1;
    chk("rstsend.in_send", {31'b0, uart_dat_we_o}, 32'd1);
    @(negedge clk);
    reset           = 1'b1;
    uart_dat_wait_i = 1'b0;
    #1;
    chk("rstsend.we_in_reset", {31'b0, uart_dat_we_o}, 32'd0);
    chk("rstsend.di_in_reset", uart_dat_di_o, 32'd0);
    we_cycles = 0;
    @(negedge clk);
    reset = 1'b0;
    rd_chk("rstsend.status", STAT, 32'h0005_0000);
    repeat (10) @(negedge clk);
    chk("rstsend.no_we", we_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000100, meaning word address of the DATA register (STATUS at BASE_ADDR+4).
REQ-002 SHALL have parameter DEPTH, default 16, meaning entries per FIFO; legal values are powers of 2 from 2 to 128.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_valid_i  input  1  bus request valid.
REQ-006 SHALL have port mem_ready_o  output  1  bus request complete this cycle.
REQ-007 SHALL have port mem_addr_i  input  32  bus byte address.
REQ-008 SHALL have port mem_wdata_i  input  32  bus write data.
REQ-009 SHALL have port mem_wstrb_i  input  4  byte strobes; 0 means read.
REQ-010 SHALL have port mem_rdata_o  output  32  bus read data, valid while mem_ready_o=1.
REQ-011 SHALL have port uart_dat_we_o  output  1  UART transmit-data write strobe.
REQ-012 SHALL have port uart_dat_re_o  output  1  UART receive-data read strobe.
REQ-013 SHALL have port uart_dat_di_o  output  32  UART transmit data: {24'b0, byte}.
REQ-014 SHALL have port uart_dat_do_i  input  32  UART receive data; 32'hFFFFFFFF means no byte.
REQ-015 SHALL have port uart_dat_wait_i  input  1  UART busy; a write is accepted only in a cycle where this is 0.

Function
REQ-016 SHALL contain a TX FIFO and an RX FIFO, each DEPTH x 8 bits, with counts of width log2(DEPTH)+1.
REQ-017 Bus requests SHALL be decoded only when mem_valid_i=1 and mem_addr_i equals BASE_ADDR or BASE_ADDR+4; other addresses SHALL give mem_ready_o=0.
REQ-018 A DATA write with mem_wstrb_i[0]=1 SHALL push mem_wdata_i[7:0] into the TX FIFO and assert mem_ready_o in the same cycle if the registered TX count is below DEPTH; otherwise mem_ready_o SHALL stay 0 (stall). A same-cycle drain pop SHALL NOT release the stall.
REQ-019 A DATA write with mem_wstrb_i[0]=0 and a nonzero strobe SHALL be acknowledged immediately with no push.
REQ-020 A DATA read SHALL complete in the same cycle.
  - RX FIFO non-empty: return {24'b0, head} and pop exactly once.
  - RX FIFO empty: return 32'hFFFFFFFF and pop nothing.
REQ-021 A STATUS read SHALL complete in the same cycle and return the following fields; unlisted bits are 0.
  - [7:0] TX count; [15:8] RX count.
  - [16] tx_empty; [17] tx_full; [18] rx_empty; [19] rx_full.
  - [20] rx_overflow (sticky).
REQ-022 A STATUS write with mem_wstrb_i[2]=1 and mem_wdata_i[20]=1 SHALL clear rx_overflow; if an overflow event occurs in the same cycle, set SHALL win.
REQ-023 The TX drain FSM SHALL have two states, IDLE and SEND.
  - IDLE -> SEND when the TX FIFO is non-empty.
  - In SEND, uart_dat_we_o=1 and uart_dat_di_o={24'b0, TX head}.
  - In SEND with uart_dat_wait_i=0: pop the TX head and go SEND -> IDLE.
  - In SEND with uart_dat_wait_i=1: hold SEND with the head unchanged.
REQ-024 In IDLE, uart_dat_we_o SHALL be 0; uart_dat_di_o SHALL show the TX head, or 0 when the TX FIFO is empty.
REQ-025 The RX capture path SHALL work combinationally each cycle when uart_dat_do_i != 32'hFFFFFFFF.
  - Assert uart_dat_re_o.
  - Push uart_dat_do_i[7:0] if the registered RX count is below DEPTH.
  - Otherwise discard the byte and set rx_overflow.
REQ-026 A bus pop and a capture push on the RX FIFO in the same cycle SHALL both take effect; the count is unchanged, including when the FIFO is full (the pop frees the slot).
REQ-027 A bus push and a drain pop on the TX FIFO in the same cycle SHALL both take effect; the count is unchanged.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; a push SHALL never be accepted when full, and a pop SHALL never occur when empty.
REQ-029 Drain throughput SHALL be one TX byte per two cycles when uart_dat_wait_i=0 continuously.

Reset
REQ-030 While reset=1 at a clk edge, the block SHALL reset to the following state, discarding FIFO contents:
  - both FIFO pointers and counts to 0;
  - FSM to IDLE;
  - rx_overflow to 0.
REQ-031 Reset SHALL force the outputs mem_ready_o=0, uart_dat_we_o=0, uart_dat_re_o=0, uart_dat_di_o=0 and mem_rdata_o=0.
REQ-032 Reset asserted mid-SEND SHALL abort the transfer: no pop, and uart_dat_we_o=0 from the reset cycle onward.

Structure
REQ-033 Register offsets (DATA 0x0, STATUS 0x4), status bit positions and the no-data constant 32'hFFFFFFFF SHALL live in shared package uart_fifo_pkg.
REQ-034 Both FIFOs SHALL be instances of one sub-module sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, reset, push, pop, wdata, rdata, count, full, empty.
  - rdata shows the head combinationally.

Verification
REQ-035 Bench SHALL write 0x41, 0x42, 0x43 to DATA with uart_dat_wait_i=0 -> uart_dat_we_o pulses carry 0x41, 0x42, 0x43 in order, and STATUS[7:0] returns to 0.
REQ-036 Bench SHALL hold uart_dat_wait_i=1 and write 17 bytes with DEPTH=16 -> first 16 acknowledged immediately, 17th stalls with mem_ready_o=0 until wait drops and one byte drains.
REQ-037 Bench SHALL drive uart_dat_do_i=0x55 for one cycle, then read DATA twice -> returns 0x00000055, then 0xFFFFFFFF.
REQ-038 Bench SHALL inject 17 RX bytes without reading -> STATUS[15:8]=16, STATUS[19]=1, STATUS[20]=1; STATUS write 0x00100000 -> bit 20 clears.
REQ-039 Bench SHALL assert reset while in SEND with 5 bytes queued -> next STATUS read returns 0x00050000 (both empty, counts 0), and no further uart_dat_we_o.
REQ-040 Bench SHALL, with the RX FIFO full, perform a bus DATA read in the same cycle as an RX capture -> no overflow, and RX count stays 16.
